// File: rtl/instr_encoder.sv
// instr_encoder: turns a compact request into RV32I instruction words.
// Most requests produce one word. A large LI produces LUI then ADDI.
// The output is a single register with a valid/ready handshake.
// Requests that cannot be encoded are accepted, emit nothing and pulse err.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [3:0]  req_alu_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err,
    output logic [15:0] emit_count
);

    // Request kinds
    localparam logic [2:0] K_NOP   = 3'b000;
    localparam logic [2:0] K_REG   = 3'b001;
    localparam logic [2:0] K_IMM   = 3'b010;
    localparam logic [2:0] K_LOAD  = 3'b011;
    localparam logic [2:0] K_STORE = 3'b100;
    localparam logic [2:0] K_AUIPC = 3'b101;
    localparam logic [2:0] K_JAL   = 3'b110;
    localparam logic [2:0] K_LI    = 3'b111;

    // RV32I major opcodes
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] pend_q, pend_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    // ALU decode results
    logic        alu_legal;
    logic        alu_f7b;
    logic [2:0]  alu_f3;
    logic        alu_shift;
    logic        alu_sub;

    // Encoder results for the current request
    logic        enc_legal;
    logic        enc_two;
    logic [31:0] enc_w0;
    logic [31:0] enc_w1;

    // LI helpers
    logic        li_small;
    logic [19:0] li_upper;
    logic [11:0] imm_shift;

    // Handshake / control strobes
    logic        accept;
    logic        load_first;
    logic        load_second;
    logic        out_fire;
    logic        out_free;

    // Map the ALU code onto {funct7[5], funct3}; unlisted codes are illegal
    always_comb begin
        alu_legal = 1'b1;
        alu_f7b   = 1'b0;
        alu_f3    = 3'b000;
        alu_shift = 1'b0;
        alu_sub   = 1'b0;
        unique case (req_alu_op)
            4'b0001: begin alu_f7b = 1'b0; alu_f3 = 3'b000; end                    // ADD
            4'b0010: begin alu_f7b = 1'b1; alu_f3 = 3'b000; alu_sub = 1'b1; end    // SUB
            4'b0011: begin alu_f7b = 1'b0; alu_f3 = 3'b100; end                    // XOR
            4'b0100: begin alu_f7b = 1'b0; alu_f3 = 3'b110; end                    // OR
            4'b0101: begin alu_f7b = 1'b0; alu_f3 = 3'b111; end                    // AND
            4'b0110: begin alu_f7b = 1'b0; alu_f3 = 3'b001; alu_shift = 1'b1; end  // SLL
            4'b0111: begin alu_f7b = 1'b0; alu_f3 = 3'b101; alu_shift = 1'b1; end  // SRL
            4'b1001: begin alu_f7b = 1'b1; alu_f3 = 3'b101; alu_shift = 1'b1; end  // SRA
            4'b1010: begin alu_f7b = 1'b0; alu_f3 = 3'b010; end                    // SLT
            4'b1011: begin alu_f7b = 1'b0; alu_f3 = 3'b011; end                    // SLTU
            default: alu_legal = 1'b0;
        endcase
    end

    // LI fits one ADDI when bits 31..11 are a pure sign extension;
    // otherwise LUI must pre-compensate for ADDI sign-extending imm[11]
    always_comb begin
        li_small  = (&req_imm[31:11]) | ~(|req_imm[31:11]);
        li_upper  = req_imm[31:12] + {19'b0, req_imm[11]};
        imm_shift = {1'b0, alu_f7b, 5'b00000, req_imm[4:0]};
    end

    // Build the instruction word(s) for the presented request
    always_comb begin
        enc_legal = 1'b1;
        enc_two   = 1'b0;
        enc_w0    = NOP_WORD;
        enc_w1    = NOP_WORD;
        unique case (req_kind)
            K_NOP: begin
                enc_w0 = NOP_WORD;
            end
            K_REG: begin
                enc_legal = alu_legal;
                enc_w0    = {1'b0, alu_f7b, 5'b00000, req_rs2, req_rs1, alu_f3, req_rd, OP_REG};
            end
            K_IMM: begin
                enc_legal = alu_legal & ~alu_sub;
                if (alu_shift) begin
                    enc_w0 = {imm_shift, req_rs1, alu_f3, req_rd, OP_IMM};
                end else begin
                    enc_w0 = {req_imm[11:0], req_rs1, alu_f3, req_rd, OP_IMM};
                end
            end
            K_LOAD: begin
                enc_w0 = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LOAD};
            end
            K_STORE: begin
                enc_w0 = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OP_STORE};
            end
            K_AUIPC: begin
                enc_w0 = {req_imm[31:12], req_rd, OP_AUIPC};
            end
            K_JAL: begin
                enc_w0 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            end
            K_LI: begin
                if (li_small) begin
                    enc_w0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
                end else begin
                    enc_two = 1'b1;
                    enc_w0  = {li_upper, req_rd, OP_LUI};
                    enc_w1  = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_IMM};
                end
            end
            default: enc_legal = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter EXPAND on a two-word LI, leave when word two loads
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (load_first && enc_two) state_d = S_EXPAND;
            S_EXPAND: if (load_second)           state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake strobes derived from state and output register
    always_comb begin
        out_fire    = out_valid_q & out_ready;
        out_free    = ~out_valid_q | out_ready;
        req_ready   = reset & (state_q == S_IDLE) & out_free;
        accept      = req_valid & req_ready;
        load_first  = accept & enc_legal;
        load_second = (state_q == S_EXPAND) & out_free;
    end

    // Next values for the output register, pending word, error and counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        pend_d      = pend_q;
        err_d       = accept & ~enc_legal;
        cnt_d       = cnt_q + {15'd0, out_fire};
        if (load_second) begin
            out_valid_d = 1'b1;
            out_instr_d = pend_q;
        end else if (load_first) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_w0;
            if (enc_two) begin
                pend_d = enc_w1;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath and status registers; reset discards any pending second word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            pend_q      <= 32'h0000_0000;
            err_q       <= 1'b0;
            cnt_q       <= 16'h0000;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign err        = err_q;
    assign emit_count = cnt_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 req_valid  input  1  request present.
REQ-004 req_ready  output  1  request accepted on cycles where req_valid and req_ready are both 1.
REQ-005 req_kind  input  3  000 NOP, 001 REG, 010 IMM, 011 LOAD, 100 STORE, 101 AUIPC, 110 JAL, 111 LI.
REQ-006 req_alu_op  input  4  ALU code: 0001 ADD, 0010 SUB, 0011 XOR, 0100 OR, 0101 AND, 0110 SLL, 0111 SRL, 1001 SRA, 1010 SLT, 1011 SLTU.
REQ-007 req_rd, req_rs1, req_rs2  input  5 each  register indices.
REQ-008 req_imm  input  32  immediate, two's complement.
REQ-009 out_valid  output  1  out_instr holds a valid word.
REQ-010 out_ready  input  1  consumer accepts word when out_valid and out_ready.
REQ-011 out_instr  output  32  RV32I instruction word.
REQ-012 err  output  1  one-cycle pulse on acceptance of an unencodable request.
REQ-013 emit_count  output  16  words delivered since reset.

Function
REQ-014 Output is a single register; out_instr and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 req_ready SHALL be 1 only when state=IDLE and (out_valid=0 or out_ready=1).
REQ-016 Latency: an accepted encodable request SHALL present its first word with out_valid=1 on the next cycle.
REQ-017 Field packing: func {funct7[5],funct3} SHALL be the inverse of the ALU map: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-018 REG: R-type, opcode 0110011, funct7 = {0, func[3], 00000}; alu_op 0000, 1000, 1100-1111 SHALL be unencodable.
REQ-019 IMM: opcode 0010011; shifts SHALL emit imm[11:5] = {0, func[3], 00000} and imm[4:0] = req_imm[4:0]; others emit req_imm[11:0]; SUB plus the REG-illegal codes SHALL be unencodable.
REQ-020 LOAD: I-type LW, opcode 0000011, funct3 010; STORE: S-type SW, opcode 0100011, funct3 010, imm split [11:5]/[4:0]; alu_op ignored for both.
REQ-021 AUIPC: U-type opcode 0010111, imm[31:12]; JAL: J-type opcode 1101111, bits {imm[20],imm[10:1],imm[11],imm[19:12]}.
REQ-022 NOP SHALL emit 0x00000013.
REQ-023 LI: if req_imm[31:11] all equal, SHALL emit one ADDI rd,x0,imm[11:0]; otherwise SHALL emit LUI rd (opcode 0110111, upper = imm[31:12] + imm[11], mod 2^20) and then ADDI rd,rd,imm[11:0].
REQ-024 States IDLE and EXPAND; two-word LI SHALL move IDLE->EXPAND on acceptance and EXPAND->IDLE when the second word loads into the output register.
REQ-025 The second word SHALL load in the cycle the first word is consumed (no bubble when out_ready=1 is held).
REQ-026 An unencodable request SHALL be accepted, emit no word, pulse err the following cycle and leave out_valid unchanged.
REQ-027 emit_count SHALL increment per out_valid&out_ready handshake and wrap 0xFFFF->0x0000.
REQ-028 Back-to-back: with out_ready held 1, one word per cycle SHALL be sustained.

Reset
REQ-029 While reset=0: out_valid=0, err=0, emit_count=0, state=IDLE, out_instr=0x00000000, req_ready=0.
REQ-030 Reset asserted mid-EXPAND SHALL discard the pending second word; after release req_ready=1 on the first clock edge.

Verification
REQ-031 REG ADD rd=1,rs1=2,rs2=3, out_ready=1 -> next cycle out_instr=0x003100B3, emit_count=1.
REQ-032 IMM SRA rd=5,rs1=5,imm=3 -> 0x4032D293; IMM SUB -> err pulse, no out_valid, emit_count unchanged.
REQ-033 LI rd=10, imm=0x12345FFF -> 0x12346537 then 0xFFF50513 on consecutive cycles; req_ready=0 during EXPAND.
REQ-034 LI rd=10, imm=0xFFFFF800 -> single 0x80000513; state stays IDLE.
REQ-035 out_ready=0 for 5 cycles with word pending -> out_instr stable, req_ready=0; release -> handshake, emit_count+1.
REQ-036 Preload emit_count to 0xFFFF via 65535 NOPs, one more NOP -> emit_count=0x0000; reset low mid-LI -> out_valid=0 immediately.
